// File: rtl/perf_monitor_array.sv
// Weighted event-counter bank with snapshot shadows, sticky overflow/threshold flags and a registered read port.
// Read data one cycle after rd_req, no backpressure; `PERF_MON_CYCLE_COUNTER_EN adds a free-running cycle counter.
module perf_monitor_array #(
   parameter int NUM_CH   = 4,
   parameter int CNT_W    = 32,
   parameter int INC_W    = 4,
   parameter int ADDR_W   = 4,
   parameter int SATURATE = 0
) (
   input  logic                      clk_main_200mhz,
   input  logic                      reset,
   input  logic [NUM_CH*INC_W-1:0]   event_inc,
   input  logic [NUM_CH-1:0]         cnt_enable,
   input  logic [NUM_CH-1:0]         cnt_clear,
   input  logic                      snapshot_req,
   input  logic [CNT_W-1:0]          threshold_value,
   input  logic [NUM_CH-1:0]         irq_clear,
   input  logic                      rd_req,
   input  logic [ADDR_W-1:0]         rd_addr,
   output logic [CNT_W-1:0]          rd_data,
   output logic                      rd_valid,
   output logic [NUM_CH-1:0]         irq_status,
   output logic [NUM_CH-1:0]         overflow_status,
   output logic                      interrupt_signal
);

   logic [CNT_W-1:0]  live_q   [NUM_CH];
   logic [CNT_W-1:0]  live_d   [NUM_CH];
   logic [CNT_W-1:0]  shadow_q [NUM_CH];
   logic [CNT_W:0]    sum      [NUM_CH];
   logic [NUM_CH-1:0] ovf_q, ovf_d;
   logic [NUM_CH-1:0] irq_q, irq_d;
   logic              int_q;
   logic [CNT_W-1:0]  rd_data_q, rd_mux;
   logic              rd_valid_q;

`ifdef PERF_MON_CYCLE_COUNTER_EN
   logic [CNT_W-1:0]  cyc_q, cyc_shadow_q;
`endif

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         sum[i]    = {1'b0, live_q[i]} + (CNT_W+1)'(event_inc[i*INC_W +: INC_W]);
         live_d[i] = live_q[i];
         ovf_d[i]  = ovf_q[i];
         if (cnt_clear[i]) begin
            live_d[i] = '0;
            ovf_d[i]  = 1'b0;
         end else if (cnt_enable[i]) begin
            if (sum[i][CNT_W]) begin
               ovf_d[i]  = 1'b1;
               live_d[i] = (SATURATE != 0) ? '1 : sum[i][CNT_W-1:0];
            end else begin
               live_d[i] = sum[i][CNT_W-1:0];
            end
         end
         // Only an upward crossing sets the flag, so a wrap back below threshold is ignored.
         irq_d[i] = (irq_q[i] & ~irq_clear[i]) |
                    ((threshold_value != '0) && (live_q[i] < threshold_value) &&
                     (live_d[i] >= threshold_value));
      end
   end

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (rd_addr == ADDR_W'(i))          rd_mux = shadow_q[i];
         if (rd_addr == ADDR_W'(NUM_CH + i)) rd_mux = live_q[i];
      end
`ifdef PERF_MON_CYCLE_COUNTER_EN
      if (rd_addr == ADDR_W'(2*NUM_CH))     rd_mux = cyc_shadow_q;
      if (rd_addr == ADDR_W'(2*NUM_CH + 1)) rd_mux = cyc_q;
`endif
   end

   always_ff @(posedge clk_main_200mhz or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            live_q[i]   <= '0;
            shadow_q[i] <= '0;
         end
         ovf_q      <= '0;
         irq_q      <= '0;
         int_q      <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            live_q[i] <= live_d[i];
            // Shadows take the pre-update value; same-cycle clear/increment only hits live.
            if (snapshot_req) shadow_q[i] <= live_q[i];
         end
         ovf_q      <= ovf_d;
         irq_q      <= irq_d;
         int_q      <= |irq_q;
         rd_valid_q <= rd_req;
         if (rd_req) rd_data_q <= rd_mux;
      end
   end

`ifdef PERF_MON_CYCLE_COUNTER_EN
   always_ff @(posedge clk_main_200mhz or posedge reset) begin
      if (reset) begin
         cyc_q        <= '0;
         cyc_shadow_q <= '0;
      end else begin
         cyc_q <= cyc_q + 1'b1;
         if (snapshot_req) cyc_shadow_q <= cyc_q;
      end
   end
`endif

   assign rd_data          = rd_data_q;
   assign rd_valid         = rd_valid_q;
   assign irq_status       = irq_q;
   assign overflow_status  = ovf_q;
   assign interrupt_signal = int_q;

endmodule

// File: tb/tb_perf_monitor_array.sv
// Directed bench: 32-bit wrap instance plus two 8-bit instances (wrap and saturate) sharing stimulus.
module tb_perf_monitor_array;

   logic        clk = 1'b0;
   logic        reset;
   int          n_cmp = 0;
   int          n_err = 0;

   logic [15:0] m_inc;
   logic [3:0]  m_en, m_clr, m_irqc;
   logic        m_snap, m_rd_req;
   logic [31:0] m_thr;
   logic [3:0]  m_rd_addr;
   logic [31:0] m_rd_data;
   logic        m_rd_valid, m_int;
   logic [3:0]  m_irq, m_ovf;

   logic [15:0] w_inc;
   logic [3:0]  w_en, w_clr, w_irqc;
   logic        w_snap, w_rd_req;
   logic [7:0]  w_thr;
   logic [3:0]  w_rd_addr;
   logic [7:0]  dw_rd_data, ds_rd_data;
   logic        dw_rd_valid, ds_rd_valid, dw_int, ds_int;
   logic [3:0]  dw_irq, ds_irq, dw_ovf, ds_ovf;

   logic [31:0] cyc_snap;

   always #5 clk = ~clk;

   perf_monitor_array #(.NUM_CH(4), .CNT_W(32), .INC_W(4), .ADDR_W(4), .SATURATE(0)) dut (
      .clk_main_200mhz(clk), .reset(reset), .event_inc(m_inc), .cnt_enable(m_en),
      .cnt_clear(m_clr), .snapshot_req(m_snap), .threshold_value(m_thr), .irq_clear(m_irqc),
      .rd_req(m_rd_req), .rd_addr(m_rd_addr), .rd_data(m_rd_data), .rd_valid(m_rd_valid),
      .irq_status(m_irq), .overflow_status(m_ovf), .interrupt_signal(m_int));

   perf_monitor_array #(.NUM_CH(4), .CNT_W(8), .INC_W(4), .ADDR_W(4), .SATURATE(0)) dut_wrap (
      .clk_main_200mhz(clk), .reset(reset), .event_inc(w_inc), .cnt_enable(w_en),
      .cnt_clear(w_clr), .snapshot_req(w_snap), .threshold_value(w_thr), .irq_clear(w_irqc),
      .rd_req(w_rd_req), .rd_addr(w_rd_addr), .rd_data(dw_rd_data), .rd_valid(dw_rd_valid),
      .irq_status(dw_irq), .overflow_status(dw_ovf), .interrupt_signal(dw_int));

   perf_monitor_array #(.NUM_CH(4), .CNT_W(8), .INC_W(4), .ADDR_W(4), .SATURATE(1)) dut_sat (
      .clk_main_200mhz(clk), .reset(reset), .event_inc(w_inc), .cnt_enable(w_en),
      .cnt_clear(w_clr), .snapshot_req(w_snap), .threshold_value(w_thr), .irq_clear(w_irqc),
      .rd_req(w_rd_req), .rd_addr(w_rd_addr), .rd_data(ds_rd_data), .rd_valid(ds_rd_valid),
      .irq_status(ds_irq), .overflow_status(ds_ovf), .interrupt_signal(ds_int));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic main_rd(input logic [3:0] a);
      m_rd_req  = 1'b1;
      m_rd_addr = a;
      step();
      m_rd_req  = 1'b0;
   endtask

   task automatic w_rd(input logic [3:0] a);
      w_rd_req  = 1'b1;
      w_rd_addr = a;
      step();
      w_rd_req  = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      m_inc = '0; m_en = '0; m_clr = '0; m_irqc = '0; m_snap = 1'b0; m_thr = '0;
      m_rd_req = 1'b0; m_rd_addr = '0;
      w_inc = '0; w_en = '0; w_clr = '0; w_irqc = '0; w_snap = 1'b0; w_thr = '0;
      w_rd_req = 1'b0; w_rd_addr = '0;
      cyc_snap = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // reset state
      check("rst_rd_data", m_rd_data, 0);
      check("rst_rd_valid", {31'd0, m_rd_valid}, 0);
      check("rst_irq", {28'd0, m_irq}, 0);
      check("rst_ovf", {28'd0, m_ovf}, 0);
      check("rst_int", {31'd0, m_int}, 0);

      // ch0 += 3 for 10 cycles
      m_en = 4'b0001; m_inc = 16'h0003;
      repeat (10) step();
      m_en = '0; m_inc = '0;
      main_rd(4'd4);
      check("ch0_rd_valid", {31'd0, m_rd_valid}, 1);
      check("ch0_live_30", m_rd_data, 30);
      step();
      check("rd_valid_pulse", {31'd0, m_rd_valid}, 0);
      check("rd_data_hold", m_rd_data, 30);

      // snapshot with same-cycle clear of ch0 at 50
      m_en = 4'b0001; m_inc = 16'h0004;
      repeat (5) step();
      m_en = '0; m_inc = '0;
      m_snap = 1'b1; m_clr = 4'b0001;
      step();
      m_snap = 1'b0; m_clr = '0;
      main_rd(4'd0);
      check("snap_shadow0", m_rd_data, 50);
      main_rd(4'd4);
      check("snap_live0_cleared", m_rd_data, 0);
      main_rd(4'd1);
      check("snap_shadow1", m_rd_data, 0);

      // threshold crossing on ch2
      m_thr = 32'd20; m_en = 4'b0100; m_inc = 16'h0500;
      repeat (3) step();
      check("thr_below", {28'd0, m_irq}, 0);
      step();
      check("thr_cross_irq", {28'd0, m_irq}, 4'b0100);
      check("thr_int_lag", {31'd0, m_int}, 0);
      step();
      check("thr_int_follow", {31'd0, m_int}, 1);
      m_en = '0; m_clr = 4'b0100;
      step();
      m_clr = '0;
      check("irq_survives_cnt_clear", {28'd0, m_irq}, 4'b0100);
      m_en = 4'b0100;
      repeat (3) step();
      m_irqc = 4'b0100;
      step();
      m_irqc = '0; m_en = '0;
      check("irq_set_beats_clear", {28'd0, m_irq}, 4'b0100);
      main_rd(4'd6);
      check("thr_live2", m_rd_data, 20);
      m_irqc = 4'b0100;
      step();
      m_irqc = '0;
      check("irq_w1c", {28'd0, m_irq}, 0);
      check("int_after_w1c", {31'd0, m_int}, 1);
      step();
      check("int_drops", {31'd0, m_int}, 0);

      // clear beats increment on ch3, unmapped addresses
      m_en = 4'b1000; m_inc = 16'h7000;
      step();
      m_en = '0;
      main_rd(4'd7);
      check("ch3_live7", m_rd_data, 7);
      m_en = 4'b1000; m_clr = 4'b1000;
      step();
      m_en = '0; m_clr = '0; m_inc = '0;
      main_rd(4'd7);
      check("ch3_clear_wins", m_rd_data, 0);
      main_rd(4'd15);
      check("unmapped15", m_rd_data, 0);
`ifndef PERF_MON_CYCLE_COUNTER_EN
      main_rd(4'd6);
      main_rd(4'd8);
      check("unmapped8", m_rd_data, 0);
      main_rd(4'd6);
      main_rd(4'd9);
      check("unmapped9", m_rd_data, 0);
`endif

      // reset in the middle of a pending read
      m_en = 4'b0010; m_inc = 16'h0090;
      step();
      m_en = '0; m_inc = '0;
      main_rd(4'd5);
      check("ch1_live9", m_rd_data, 9);
      m_rd_req = 1'b1; m_rd_addr = 4'd5;
      #2 reset = 1'b1;
      #1;
      check("async_rst_valid", {31'd0, m_rd_valid}, 0);
      check("async_rst_data", m_rd_data, 0);
      step();
      check("rst_drops_read", {31'd0, m_rd_valid}, 0);
      reset = 1'b0; m_rd_req = 1'b0;
      main_rd(4'd5);
      check("post_rst_live1", m_rd_data, 0);
      main_rd(4'd0);
      check("post_rst_shadow0", m_rd_data, 0);

      // 8-bit wrap vs saturate on ch1
      w_en = 4'b0010; w_inc = 16'h00F0;
      repeat (16) step();
      w_inc = 16'h00E0;
      step();
      check("w_no_ovf_254", {28'd0, dw_ovf}, 0);
      check("s_no_ovf_254", {28'd0, ds_ovf}, 0);
      w_inc = 16'h0030;
      step();
      w_en = '0; w_inc = '0;
      w_rd(4'd5);
      check("wrap_to_1", {24'd0, dw_rd_data}, 1);
      check("sat_to_255", {24'd0, ds_rd_data}, 255);
      check("wrap_ovf", {28'd0, dw_ovf}, 4'b0010);
      check("sat_ovf", {28'd0, ds_ovf}, 4'b0010);
      check("wrap_no_irq_thr0", {28'd0, dw_irq}, 0);
      w_en = 4'b0010; w_inc = 16'h0030;
      step();
      w_en = '0; w_inc = '0;
      w_rd(4'd5);
      check("wrap_to_4", {24'd0, dw_rd_data}, 4);
      check("sat_holds_255", {24'd0, ds_rd_data}, 255);
      check("sat_ovf_stays", {28'd0, ds_ovf}, 4'b0010);
      w_clr = 4'b0010;
      step();
      w_clr = '0;
      check("wrap_ovf_cleared", {28'd0, dw_ovf}, 0);
      check("sat_ovf_cleared", {28'd0, ds_ovf}, 0);

`ifdef PERF_MON_CYCLE_COUNTER_EN
      reset = 1'b1;
      step();
      reset = 1'b0;
      repeat (100) step();
      m_snap = 1'b1;
      step();
      m_snap = 1'b0;
      main_rd(4'd8);
      check("cyc_shadow_100", m_rd_data, 100);
      cyc_snap = m_rd_data;
      main_rd(4'd9);
      check("cyc_live_gt_shadow", {31'd0, (m_rd_data > cyc_snap)}, 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/perf_monitor_array.md
Name: perf_monitor_array

Overview:
- Parametrised event-counter bank: the next generation of the fixed four-counter performance logic in our integration IP.
- Each of NUM_CH channels accumulates a weighted event increment, with per-channel enable, clear, overflow flag and threshold interrupt.
- Global snapshot copies all live counters into shadow registers for coherent readout.
- Sits in the main clock domain. Event sources from other domains are synchronised before they reach this block.

Parameters:
- NUM_CH, 4, number of counter channels (1..16)
- CNT_W, 32, counter width in bits
- INC_W, 4, per-channel increment width; an increment of 0 means no event
- ADDR_W, 4, read address width; must be >= clog2(2*NUM_CH+2)
- SATURATE, 0, overflow mode: 1 = counter sticks at all-ones, 0 = counter wraps

Ports:
- clk_main_200mhz  input  1  block clock, rising edge
- reset  input  1  asynchronous, active-high reset
- event_inc  input  NUM_CH*INC_W  per-channel increment; channel i occupies bits [i*INC_W +: INC_W]
- cnt_enable  input  NUM_CH  per-channel count enable
- cnt_clear  input  NUM_CH  per-channel synchronous clear pulse
- snapshot_req  input  1  capture all live counters into shadows
- threshold_value  input  CNT_W  shared interrupt threshold; 0 disables threshold detection
- irq_clear  input  NUM_CH  write-1-to-clear for irq_status
- rd_req  input  1  read strobe
- rd_addr  input  ADDR_W  read address
- rd_data  output  CNT_W  read data
- rd_valid  output  1  read data valid
- irq_status  output  NUM_CH  sticky per-channel threshold flags
- overflow_status  output  NUM_CH  sticky per-channel overflow flags
- interrupt_signal  output  1  registered OR of irq_status

Behaviour:
- Reset: every live counter, shadow, irq_status, overflow_status, rd_data, rd_valid and interrupt_signal is 0.
- Counter update per channel per cycle, in priority order:
  - cnt_clear[i]: counter <= 0 and overflow_status[i] <= 0. Clear beats increment in the same cycle.
  - Else if cnt_enable[i]: sum = counter + inc, computed at CNT_W+1 bits.
    - If sum carries and SATURATE=1: counter <= all-ones.
    - If sum carries and SATURATE=0: counter <= sum mod 2^CNT_W.
    - Any carry sets overflow_status[i].
    - When the counter is already at all-ones in saturate mode, further increments set no new state; overflow stays 1.
  - Else: counter holds.
- Threshold:
  - irq_status[i] sets on a crossing: old counter < threshold_value and new counter >= threshold_value, with threshold_value != 0.
  - A wrap that lands back below the threshold does not set the flag.
  - irq_clear[i] clears the flag. If set and clear occur in the same cycle, set wins.
- interrupt_signal: registered |irq_status, so it lags irq_status by one cycle.
- Snapshot:
  - On snapshot_req, every shadow[i] <= live counter value as it was before this cycle's update.
  - A same-cycle clear or increment lands in the live counter only.
- Read:
  - rd_req with rd_addr is followed by rd_valid=1 and rd_data on the next cycle; rd_valid is high for that single cycle.
  - Address map: 0..NUM_CH-1 = shadow[i]; NUM_CH..2*NUM_CH-1 = live[i-NUM_CH], sampled as the register value in the cycle of rd_req; any other address returns 0.
  - Back-to-back rd_req every cycle is supported at full throughput.
  - rd_data holds its last value while rd_valid=0.
- Asserting reset mid-operation clears all state asynchronously. A read pending at that moment is dropped and rd_valid returns 0.

Optional Feature:
- Macro: PERF_MON_CYCLE_COUNTER_EN.
- Defined:
  - Adds a CNT_W free-running cycle counter: increments every cycle, always wraps, 0 at reset.
  - snapshot_req copies it to a cycle shadow.
  - Readable at rd_addr 2*NUM_CH (cycle shadow) and 2*NUM_CH+1 (live cycle counter).
  - Gives software an elapsed-time base for rate computation.
- Undefined: no cycle counter logic is built, and addresses 2*NUM_CH and 2*NUM_CH+1 return 0 like any other unmapped address.

Test Plan:
- Reset, then enable ch0, event_inc ch0=3 for 10 cycles, rd_addr=4 (live ch0) -> rd_data=30 one cycle later with rd_valid pulse.
- CNT_W=8, SATURATE=0: preload ch1 to 254, inc=3 -> counter 1, overflow_status[1]=1; rerun with SATURATE=1 -> counter 255 and holds at 255.
- threshold_value=20, ch2 inc=5: irq_status[2] rises on the cycle the counter goes 15->20 and interrupt_signal follows one cycle later; irq_clear and a new crossing in the same cycle -> irq_status[2] stays 1.
- snapshot_req in the same cycle as cnt_clear[0] with ch0=50 -> rd_addr=0 returns 50 and rd_addr=4 returns 0.
- cnt_clear[3] and event_inc ch3=7 in the same cycle -> counter 0; rd_addr=15 (unmapped, NUM_CH=4, macro undefined) -> rd_data=0.
- Macro defined: 100 cycles after reset, snapshot -> rd_addr=8 returns the pre-update cycle count (100 ±0 per bench alignment), and reading rd_addr=9 returns a value > rd_addr=8.
